boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter I_ADDRESSWIDTH, default 8, meaning the instruction-memory boot-port address width.
REQ-002 SHALL have parameter I_SIZE, default 64, meaning the maximum number of instruction words loadable.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that begins a load.
REQ-006 SHALL have ports in_valid, input, 1 bit, and in_data, input, 32 bits: the source word stream.
REQ-007 SHALL have port in_ready, output, 1 bit: the word is accepted when in_valid & in_ready.
REQ-008 SHALL have ports boot_iaddr, output, 8 bits; boot_idata, output, 32 bits; boot_iwe, output, 1 bit: the instruction-memory boot write port.
REQ-009 SHALL have port cpu_resetn, output, 1 bit: active-low hold-in-reset to the processor.
REQ-010 SHALL have ports done, output, 1 bit, and error, output, 1 bit: status flags.

Function
REQ-011 SHALL implement states IDLE, HDR, LOAD, CSUM, DONE, ERR.
REQ-012 SHALL move IDLE->HDR on start; start SHALL be ignored in HDR, LOAD and CSUM.
REQ-013 SHALL assert in_ready only in HDR, LOAD and CSUM.
REQ-014 SHALL treat the first accepted word in HDR as the length N, using in_data[15:0].
REQ-015 SHALL transition HDR->ERR if N > I_SIZE, HDR->DONE (or HDR->CSUM when checksum is enabled) if N = 0, and HDR->LOAD otherwise.
REQ-016 SHALL, for the k-th data word accepted in LOAD (k = 0..N-1), drive boot_iwe=1, boot_iaddr=k and boot_idata=word for exactly one cycle, starting on the cycle after acceptance (latency 1).
REQ-017 SHALL drive boot_iwe=0 in every cycle without a word accepted on the previous cycle; in_valid gaps SHALL insert no writes and no address advance.
REQ-018 SHALL keep the word index wide enough to hold I_SIZE; the address SHALL never wrap, since N <= I_SIZE is enforced.
REQ-019 SHALL, on acceptance of word N-1, move to DONE, or to CSUM when checksum is enabled.
REQ-020 SHALL hold cpu_resetn=0 in all states except DONE; in DONE, cpu_resetn=1 and done=1.
REQ-021 SHALL assert error=1 only in ERR; ERR SHALL drive cpu_resetn=0.
REQ-022 SHALL move DONE->HDR or ERR->HDR on start, clearing done and error on that same edge and driving cpu_resetn=0.
REQ-023 SHALL register every output (no combinational input-to-output path).

Reset
REQ-024 SHALL, on reset, drive state=IDLE, in_ready=0, boot_iwe=0, boot_iaddr=0, boot_idata=0, cpu_resetn=0, done=0, error=0, index=0 and checksum=0.
REQ-025 SHALL, when reset occurs mid-load, abort the load at the next edge and issue no further writes; partially written memory contents are don't-care.

Configuration
REQ-026 SHALL, with BOOT_CHECKSUM_EN defined, accumulate a 32-bit modulo-2^32 sum of the N data words, excluding the header, and compare it with the single word accepted in CSUM: equal -> DONE, unequal -> ERR.
REQ-027 SHALL, without BOOT_CHECKSUM_EN, contain no CSUM state and no accumulator, and LOAD/HDR SHALL go directly to DONE.

Structure
REQ-028 SHALL place the state enum, the header length-field width (16) and the checksum width (32) in shared package boot_pkg.
REQ-029 SHALL be a single module with no sub-module; the counter, accumulator and FSM are inline.

Verification
REQ-030 SHALL verify: header 3, words 0xA,0xB,0xC, continuous valid -> writes (0,0xA),(1,0xB),(2,0xC) on consecutive cycles, then done=1 and cpu_resetn=1.
REQ-031 SHALL verify: header 64 with a 2-cycle in_valid gap after every word -> 64 writes at addresses 0..63, no extra boot_iwe pulses, and done=1.
REQ-032 SHALL verify: header 65 -> error=1, zero writes, cpu_resetn=0; a following start with header 1 and word 0x5 -> write (0,0x5) and done=1.
REQ-033 SHALL verify: header 0 -> done=1 with zero writes (checksum word 0 when BOOT_CHECKSUM_EN is defined).
REQ-034 SHALL verify: reset asserted after the 2nd of 5 words -> no further boot_iwe pulses, all outputs at reset values, and start ignored until reset deasserts.
REQ-035 SHALL verify, with BOOT_CHECKSUM_EN: words 1,2,3 with checksum 6 -> done=1; with checksum 7 -> error=1 and cpu_resetn=0.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and widths for the boot loader.
// State set depends on BOOT_CHECKSUM_EN (adds CSUM and the word-sum accumulator).
package boot_pkg;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned CSUM_W = 32;
  localparam int unsigned DATA_W = 32;

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, LOAD, CSUM, DONE, ERR} boot_state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, LOAD, DONE, ERR} boot_state_t;
`endif

  // Length field of the header word
  function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] w);
    return w[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Boot loader bus: word-stream source side plus instruction-memory write port and status.
interface boot_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] boot_iaddr;
  logic [31:0]       boot_idata;
  logic              boot_iwe;
  logic              cpu_resetn;
  logic              done;
  logic              error;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, boot_iaddr, boot_idata, boot_iwe, cpu_resetn, done, error
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, boot_iaddr, boot_idata, boot_iwe, cpu_resetn, done, error
  );
endinterface

// File: rtl/boot_loader.sv
// Streams a length-prefixed image into instruction memory while holding the CPU in reset.
// Define BOOT_CHECKSUM_EN to require a trailing modulo-2^32 sum word after the data.
import boot_pkg::*;

module boot_loader #(
  parameter int unsigned I_ADDRESSWIDTH = 8,
  parameter int unsigned I_SIZE         = 64
) (
  input  logic          clk,
  input  logic          reset,
  boot_loader_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(I_SIZE + 1);

  boot_state_t               r_state;
  logic                      r_in_ready;
  logic                      r_iwe;
  logic [I_ADDRESSWIDTH-1:0] r_iaddr;
  logic [DATA_W-1:0]         r_idata;
  logic                      r_cpu_resetn;
  logic                      r_done;
  logic                      r_error;
  logic [IDX_W-1:0]          r_index;
  logic [IDX_W-1:0]          r_last;
`ifdef BOOT_CHECKSUM_EN
  logic [CSUM_W-1:0]         r_sum;
`endif

  logic             w_accept;
  logic [LEN_W-1:0] w_hdr_len;
  logic             w_len_over;
  logic             w_last;

  assign w_accept   = bus.in_valid & r_in_ready;
  assign w_hdr_len  = hdr_len(bus.in_data);
  assign w_len_over = w_hdr_len > LEN_W'(I_SIZE);
  assign w_last     = (r_index == r_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_in_ready   <= 1'b0;
      r_iwe        <= 1'b0;
      r_iaddr      <= '0;
      r_idata      <= '0;
      r_cpu_resetn <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_index      <= '0;
      r_last       <= '0;
`ifdef BOOT_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      r_iwe <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state    <= HDR;
            r_in_ready <= 1'b1;
          end
        end

        HDR: begin
          if (w_accept) begin
            r_index <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_sum   <= '0;
`endif
            if (w_len_over) begin
              r_state    <= ERR;
              r_in_ready <= 1'b0;
              r_error    <= 1'b1;
            end else if (w_hdr_len == '0) begin
`ifdef BOOT_CHECKSUM_EN
              r_state      <= CSUM;
`else
              r_state      <= DONE;
              r_in_ready   <= 1'b0;
              r_done       <= 1'b1;
              r_cpu_resetn <= 1'b1;
`endif
            end else begin
              r_state <= LOAD;
              r_last  <= IDX_W'(w_hdr_len - LEN_W'(1));
            end
          end
        end

        // One write per accepted word; in_valid gaps leave index and address untouched
        LOAD: begin
          if (w_accept) begin
            r_iwe   <= 1'b1;
            r_iaddr <= I_ADDRESSWIDTH'(r_index);
            r_idata <= bus.in_data;
            r_index <= r_index + IDX_W'(1);
`ifdef BOOT_CHECKSUM_EN
            r_sum   <= r_sum + bus.in_data;
            if (w_last) r_state <= CSUM;
`else
            if (w_last) begin
              r_state      <= DONE;
              r_in_ready   <= 1'b0;
              r_done       <= 1'b1;
              r_cpu_resetn <= 1'b1;
            end
`endif
          end
        end

`ifdef BOOT_CHECKSUM_EN
        CSUM: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (bus.in_data == r_sum) begin
              r_state      <= DONE;
              r_done       <= 1'b1;
              r_cpu_resetn <= 1'b1;
            end else begin
              r_state <= ERR;
              r_error <= 1'b1;
            end
          end
        end
`endif

        DONE: begin
          if (bus.start) begin
            r_state      <= HDR;
            r_in_ready   <= 1'b1;
            r_done       <= 1'b0;
            r_cpu_resetn <= 1'b0;
          end
        end

        ERR: begin
          if (bus.start) begin
            r_state    <= HDR;
            r_in_ready <= 1'b1;
            r_error    <= 1'b0;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.boot_iwe   = r_iwe;
  assign bus.boot_iaddr = r_iaddr;
  assign bus.boot_idata = r_idata;
  assign bus.cpu_resetn = r_cpu_resetn;
  assign bus.done       = r_done;
  assign bus.error      = r_error;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: vector table of load scenarios plus a mid-load reset sequence.
// Honours BOOT_CHECKSUM_EN the same way as the design.
module tb_boot_loader;

  localparam int unsigned AW     = 8;
  localparam int unsigned I_SIZE = 64;

  logic clk;
  logic reset;

  boot_loader_if #(.ADDR_W(AW)) bus ();

  boot_loader #(.I_ADDRESSWIDTH(AW), .I_SIZE(I_SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [15:0] hdr;
    logic [31:0] base;
    int          gap;
    logic [31:0] csum_delta;
    bit          exp_done;
    int          exp_writes;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   n_wr = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (bus.boot_iwe === 1'b1) begin
      n_wr++;
      if (n_wr == 1) first_cyc = cyc;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(bus.boot_iaddr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.boot_iaddr), 32'(e.addr));
        chk("wr_data", bus.boot_idata, e.data);
      end
    end
  end

  // Present a word from a negedge and hold it until accepted
  task automatic send_word(input logic [31:0] d, input int gap);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    else @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_flags"}, 32'({bus.boot_iwe, bus.in_ready, bus.cpu_resetn, bus.done, bus.error}), 32'd0);
    chk({name, "_iaddr"}, 32'(bus.boot_iaddr), 32'd0);
    chk({name, "_idata"}, bus.boot_idata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] sum;
    vec_t v;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    vecs.push_back('{16'd3,  32'h0000_000A, 0, 32'd0, 1'b1, 3});
    vecs.push_back('{16'd64, 32'h0000_1000, 2, 32'd0, 1'b1, 64});
    vecs.push_back('{16'd65, 32'h0000_0000, 0, 32'd0, 1'b0, 0});
    vecs.push_back('{16'd1,  32'h0000_0005, 0, 32'd0, 1'b1, 1});
    vecs.push_back('{16'd0,  32'h0000_0000, 0, 32'd0, 1'b1, 0});
    vecs.push_back('{16'd5,  32'hDEAD_0000, 1, 32'd0, 1'b1, 5});
`ifdef BOOT_CHECKSUM_EN
    vecs.push_back('{16'd3,  32'h0000_0001, 0, 32'd0, 1'b1, 3});
    vecs.push_back('{16'd3,  32'h0000_0001, 0, 32'd1, 1'b0, 3});
`endif

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_hold");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    foreach (vecs[i]) begin
      v    = vecs[i];
      n_wr = 0;
      sum  = '0;
      pulse_start();
      chk($sformatf("v%0d_start_ready", i), 32'(bus.in_ready), 32'd1);
      chk($sformatf("v%0d_start_status", i), 32'({bus.done, bus.error, bus.cpu_resetn}), 32'd0);

      send_word({16'h0, v.hdr}, 0);
      if (v.hdr <= 16'(I_SIZE)) begin
        for (int k = 0; k < int'(v.hdr); k++) begin
          d = v.base + 32'(k);
          sum += d;
          exp_q.push_back('{AW'(k), d});
          send_word(d, v.gap);
        end
`ifdef BOOT_CHECKSUM_EN
        send_word(sum + v.csum_delta, 0);
`endif
      end

      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_done", i), 32'(bus.done), 32'(v.exp_done));
      chk($sformatf("v%0d_error", i), 32'(bus.error), 32'(!v.exp_done));
      chk($sformatf("v%0d_cpu_resetn", i), 32'(bus.cpu_resetn), 32'(v.exp_done));
      chk($sformatf("v%0d_ready_low", i), 32'(bus.in_ready), 32'd0);
      chk($sformatf("v%0d_writes", i), 32'(n_wr), 32'(v.exp_writes));
      chk($sformatf("v%0d_pending", i), 32'(exp_q.size()), 32'd0);
      if (v.gap == 0 && v.exp_writes > 1)
        chk($sformatf("v%0d_back_to_back", i), 32'(last_cyc - first_cyc), 32'(v.exp_writes - 1));
    end

    // Reset lands after the 2nd of 5 words; start and valid are held during reset
    n_wr = 0;
    pulse_start();
    send_word(32'd5, 0);
    exp_q.push_back('{AW'(0), 32'h100});
    send_word(32'h100, 0);
    exp_q.push_back('{AW'(1), 32'h101});
    send_word(32'h101, 0);
    reset        = 1'b1;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h102;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_reset_outputs($sformatf("midreset%0d", k));
    end
    reset        = 1'b0;
    bus.start    = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_idle_ready", 32'(bus.in_ready), 32'd0);
    chk("midreset_writes", 32'(n_wr), 32'd2);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_no_late_write", 32'(n_wr), 32'd2);
    chk("midreset_pending", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
